csr_file_m: RTL and testbench

Machine-mode CSR unit for the cotm32 core, the parametrised successor of the four-register trap CSR store. It adds `mstatus`, `mie`, `mip`, `mscratch`, read-only identification CSRs and 64-bit `mcycle`/`minstret` counters split into MXLEN halves. It also handles trap-entry and `mret` side effects, interrupt gating and vectored `mtvec` target generation. It sits beside the decode/execute stage and feeds the trap controller and PC mux.

---
 rtl/csr_file_m.sv | 244 ++++++++++++++++++++++++
 tb/tb_csr_file_m.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file_m.sv
// Machine-mode CSR unit for the cotm32 core.
//
// Holds the trap CSRs (mstatus, mie, mip, mtvec, mscratch, mepc, mcause,
// mtval), constant identification CSRs (misa, mhartid) and the 64-bit
// mcycle/minstret counters. Applies trap-entry and mret side effects, gates
// interrupts and produces the (optionally vectored) trap target.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_op, i_addr          CSR operation (NONE/RW/RS/RC) and address
//   i_we, i_wdata         write intent and write operand
//   i_pc                  PC of the trapping instruction
//   i_trap_req            trap entry this cycle
//   i_trap_cause/_tval    cause (MSB = interrupt) and trap value
//   i_mret                mret retiring this cycle
//   i_instret             instruction retired this cycle
//   i_irq_sw/_timer/_ext  level-sensitive interrupt lines
//   o_rdata               combinational read data (0 on illegal access)
//   o_mtvec, o_mepc       current register values
//   o_trap_pc             trap target address
//   o_irq_pending         enabled interrupt pending while MIE set
//   o_t_illegal_inst      illegal CSR access

package zicsr_pkg;
  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_RW   = 2'd1,
    CSR_RS   = 2'd2,
    CSR_RC   = 2'd3
  } zicsr_csr_op_t;
endpackage

module csr_file_m
  import zicsr_pkg::*;
#(
  parameter int unsigned       MXLEN        = 32,
  parameter bit                HAS_COUNTERS = 1'b1,
  parameter bit                VECTORED_EN  = 1'b1,
  parameter logic [MXLEN-1:0]  MHARTID      = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  zicsr_csr_op_t      i_op,
  input  logic [11:0]        i_addr,
  input  logic               i_we,
  input  logic [MXLEN-1:0]   i_wdata,
  input  logic [MXLEN-1:0]   i_pc,
  input  logic               i_trap_req,
  input  logic [MXLEN-1:0]   i_trap_cause,
  input  logic [MXLEN-1:0]   i_trap_tval,
  input  logic               i_mret,
  input  logic               i_instret,
  input  logic               i_irq_sw,
  input  logic               i_irq_timer,
  input  logic               i_irq_ext,
  output logic [MXLEN-1:0]   o_rdata,
  output logic [MXLEN-1:0]   o_mtvec,
  output logic [MXLEN-1:0]   o_mepc,
  output logic [MXLEN-1:0]   o_trap_pc,
  output logic               o_irq_pending,
  output logic               o_t_illegal_inst
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [MXLEN-1:0] MISA_VAL = MXLEN'(32'h4000_0100);

  // Architectural state
  logic               mstatus_mie_reg;
  logic               mstatus_mpie_reg;
  logic [2:0]         mie_reg;          // {MEIE, MTIE, MSIE}
  logic [2:0]         mip_reg;          // {MEIP, MTIP, MSIP}
  logic [MXLEN-3:0]   mtvec_base_reg;
  logic               mtvec_mode_reg;   // only modes 00 and 01 exist
  logic [MXLEN-1:0]   mscratch_reg;
  logic [MXLEN-1:0]   mepc_reg;
  logic [MXLEN-1:0]   mcause_reg;
  logic [MXLEN-1:0]   mtval_reg;
  logic [2*MXLEN-1:0] mcycle_reg;
  logic [2*MXLEN-1:0] minstret_reg;

  // Places the three interrupt bits at their architectural positions 3/7/11.
  function automatic logic [MXLEN-1:0] irq_word(input logic [2:0] bits);
    logic [MXLEN-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      w[4*i+3] = bits[i];
    end
    return w;
  endfunction

  // Read decode
  logic             csr_hit;
  logic [MXLEN-1:0] csr_old;
  logic [MXLEN-1:0] mstatus_word;

  always_comb begin
    mstatus_word       = '0;
    mstatus_word[3]    = mstatus_mie_reg;
    mstatus_word[7]    = mstatus_mpie_reg;
    mstatus_word[12:11] = 2'b11;            // MPP hard-wired to M-mode
  end

  always_comb begin
    csr_hit = 1'b1;
    csr_old = '0;
    case (i_addr)
      ADDR_MSTATUS:   csr_old = mstatus_word;
      ADDR_MISA:      csr_old = MISA_VAL;
      ADDR_MIE:       csr_old = irq_word(mie_reg);
      ADDR_MTVEC:     csr_old = {mtvec_base_reg, 1'b0, mtvec_mode_reg};
      ADDR_MSCRATCH:  csr_old = mscratch_reg;
      ADDR_MEPC:      csr_old = mepc_reg;
      ADDR_MCAUSE:    csr_old = mcause_reg;
      ADDR_MTVAL:     csr_old = mtval_reg;
      ADDR_MIP:       csr_old = irq_word(mip_reg);
      ADDR_MHARTID:   csr_old = MHARTID;
      ADDR_MCYCLE:    if (HAS_COUNTERS) csr_old = mcycle_reg[MXLEN-1:0];
                      else              csr_hit = 1'b0;
      ADDR_MCYCLEH:   if (HAS_COUNTERS) csr_old = mcycle_reg[2*MXLEN-1:MXLEN];
                      else              csr_hit = 1'b0;
      ADDR_MINSTRET:  if (HAS_COUNTERS) csr_old = minstret_reg[MXLEN-1:0];
                      else              csr_hit = 1'b0;
      ADDR_MINSTRETH: if (HAS_COUNTERS) csr_old = minstret_reg[2*MXLEN-1:MXLEN];
                      else              csr_hit = 1'b0;
      default:        csr_hit = 1'b0;
    endcase
  end

  // Address space 0xC00-0xFFF is read-only; writing it is illegal even when
  // the register exists.
  logic illegal;
  assign illegal = (i_op != CSR_NONE) &&
                   (!csr_hit || (i_we && (i_addr[11:10] == 2'b11)));

  logic [MXLEN-1:0] wval;
  always_comb begin
    wval = csr_old;
    case (i_op)
      CSR_RW:  wval = i_wdata;
      CSR_RS:  wval = csr_old | i_wdata;
      CSR_RC:  wval = csr_old & ~i_wdata;
      default: wval = csr_old;
    endcase
  end

  // Trap and mret take precedence; a colliding CSR write is discarded.
  logic csr_write;
  assign csr_write = (i_op != CSR_NONE) && i_we && !illegal && !i_trap_req && !i_mret;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_reg          <= '0;
      mip_reg          <= '0;
      mtvec_base_reg   <= '0;
      mtvec_mode_reg   <= 1'b0;
      mscratch_reg     <= '0;
      mepc_reg         <= '0;
      mcause_reg       <= '0;
      mtval_reg        <= '0;
    end else begin
      mip_reg <= {i_irq_ext, i_irq_timer, i_irq_sw};
      if (i_trap_req) begin
        mepc_reg         <= {i_pc[MXLEN-1:2], 2'b00};
        mcause_reg       <= i_trap_cause;
        mtval_reg        <= i_trap_tval;
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
      end else if (i_mret) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
      end else if (csr_write) begin
        case (i_addr)
          ADDR_MSTATUS: begin
            mstatus_mie_reg  <= wval[3];
            mstatus_mpie_reg <= wval[7];
          end
          ADDR_MIE:      mie_reg <= {wval[11], wval[7], wval[3]};
          ADDR_MTVEC: begin
            mtvec_base_reg <= wval[MXLEN-1:2];
            // MODE is WARL: reserved encodings 1x leave the old mode intact.
            if (VECTORED_EN && !wval[1]) mtvec_mode_reg <= wval[0];
          end
          ADDR_MSCRATCH: mscratch_reg <= wval;
          ADDR_MEPC:     mepc_reg     <= {wval[MXLEN-1:2], 2'b00};
          ADDR_MCAUSE:   mcause_reg   <= wval;
          ADDR_MTVAL:    mtval_reg    <= wval;
          default: ;
        endcase
      end
    end
  end

  // Counters keep running through traps; a write to either half suppresses
  // the increment of the whole 64-bit value for that cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mcycle_reg   <= '0;
      minstret_reg <= '0;
    end else begin
      if (csr_write && i_addr == ADDR_MCYCLE)
        mcycle_reg[MXLEN-1:0] <= wval;
      else if (csr_write && i_addr == ADDR_MCYCLEH)
        mcycle_reg[2*MXLEN-1:MXLEN] <= wval;
      else
        mcycle_reg <= mcycle_reg + 1'b1;

      if (csr_write && i_addr == ADDR_MINSTRET)
        minstret_reg[MXLEN-1:0] <= wval;
      else if (csr_write && i_addr == ADDR_MINSTRETH)
        minstret_reg[2*MXLEN-1:MXLEN] <= wval;
      else if (i_instret)
        minstret_reg <= minstret_reg + 1'b1;
    end
  end

  // Vectored mode only offsets asynchronous causes.
  logic [MXLEN-1:0] vec_off;
  assign vec_off = (mtvec_mode_reg && i_trap_cause[MXLEN-1])
                 ? MXLEN'({i_trap_cause[4:0], 2'b00}) : '0;

  assign o_trap_pc        = {mtvec_base_reg, 2'b00} + vec_off;
  assign o_rdata          = illegal ? '0 : csr_old;
  assign o_t_illegal_inst = illegal;
  assign o_mtvec          = {mtvec_base_reg, 1'b0, mtvec_mode_reg};
  assign o_mepc           = mepc_reg;
  assign o_irq_pending    = mstatus_mie_reg && |(mip_reg & mie_reg);

endmodule

// File: tb/tb_csr_file_m.sv
// Randomised and directed bench for csr_file_m against a word-level model.
module tb_csr_file_m;
  import zicsr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  zicsr_csr_op_t op;
  logic [11:0]   addr;
  logic          we;
  logic [31:0]   wdata, pc, cause, tval;
  logic          trap, mret, instret;
  logic          irq_sw, irq_timer, irq_ext;
  logic [31:0]   rdata, mtvec_o, mepc_o, trap_pc;
  logic          irq_pend, illegal;

  csr_file_m dut (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_addr(addr), .i_we(we),
    .i_wdata(wdata), .i_pc(pc), .i_trap_req(trap), .i_trap_cause(cause),
    .i_trap_tval(tval), .i_mret(mret), .i_instret(instret),
    .i_irq_sw(irq_sw), .i_irq_timer(irq_timer), .i_irq_ext(irq_ext),
    .o_rdata(rdata), .o_mtvec(mtvec_o), .o_mepc(mepc_o), .o_trap_pc(trap_pc),
    .o_irq_pending(irq_pend), .o_t_illegal_inst(illegal)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  // Reference state, kept as whole architectural words.
  logic [31:0] m_mstatus = 32'h1800, m_mie = 0, m_mip = 0, m_mtvec = 0;
  logic [31:0] m_mscratch = 0, m_mepc = 0, m_mcause = 0, m_mtval = 0;
  logic [63:0] m_cycle = 0, m_instret = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_read(input logic [11:0] a, output logic [31:0] v);
    v = 32'h0;
    ref_read = 1'b1;
    case (a)
      12'h300: v = m_mstatus;
      12'h301: v = 32'h4000_0100;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = m_mip;
      12'hB00: v = m_cycle[31:0];
      12'hB80: v = m_cycle[63:32];
      12'hB02: v = m_instret[31:0];
      12'hB82: v = m_instret[63:32];
      12'hF14: v = 32'h0;
      default: ref_read = 1'b0;
    endcase
  endfunction

  function automatic logic exp_illegal(input logic hit);
    return (op != CSR_NONE) && (!hit || (we && addr[11:10] == 2'b11));
  endfunction

  task automatic model_update();
    logic [31:0] old, nv;
    logic        hit, ill, do_wr;
    logic [63:0] cyc_n, ins_n;
    if (rst) begin
      m_mstatus = 32'h1800; m_mie = 0; m_mip = 0; m_mtvec = 0;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      m_cycle = 0; m_instret = 0;
      return;
    end
    hit   = ref_read(addr, old);
    ill   = exp_illegal(hit);
    do_wr = (op != CSR_NONE) && we && !ill && !trap && !mret;
    case (op)
      CSR_RW:  nv = wdata;
      CSR_RS:  nv = old | wdata;
      default: nv = old & ~wdata;
    endcase
    cyc_n = m_cycle + 64'd1;
    ins_n = instret ? m_instret + 64'd1 : m_instret;
    if (trap) begin
      m_mepc    = pc & ~32'h3;
      m_mcause  = cause;
      m_mtval   = tval;
      m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
    end else if (mret) begin
      m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
    end else if (do_wr) begin
      case (addr)
        12'h300: m_mstatus  = (nv & 32'h88) | 32'h1800;
        12'h304: m_mie      = nv & 32'h888;
        12'h305: m_mtvec    = (nv & ~32'h3) | (nv[1] ? (m_mtvec & 32'h1) : {31'b0, nv[0]});
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv & ~32'h3;
        12'h342: m_mcause   = nv;
        12'h343: m_mtval    = nv;
        12'hB00: cyc_n = {m_cycle[63:32], nv};
        12'hB80: cyc_n = {nv, m_cycle[31:0]};
        12'hB02: ins_n = {m_instret[63:32], nv};
        12'hB82: ins_n = {nv, m_instret[31:0]};
        default: ;
      endcase
    end
    m_cycle   = cyc_n;
    m_instret = ins_n;
    m_mip     = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
  endtask

  // One clock: compare combinational outputs mid-cycle, advance the model,
  // then cross the rising edge.
  task automatic tick();
    logic [31:0] v, tp;
    logic        hit, ill;
    @(negedge clk);
    n_txn++;
    $display("txn %0d rst=%b op=%0d addr=%h we=%b wd=%h trap=%b mret=%b rd=%h ill=%b irq=%b",
             n_txn, rst, op, addr, we, wdata, trap, mret, rdata, illegal, irq_pend);
    if (!rst) begin
      hit = ref_read(addr, v);
      ill = exp_illegal(hit);
      check("illegal", illegal, ill);
      if (op != CSR_NONE) check("rdata", rdata, ill ? 32'h0 : v);
      check("mtvec", mtvec_o, m_mtvec);
      check("mepc", mepc_o, m_mepc);
      tp = m_mtvec & ~32'h3;
      if (m_mtvec[1:0] == 2'b01 && cause[31]) tp = tp + (cause & 32'h1f) * 4;
      check("trap_pc", trap_pc, tp);
      check("irq_pending", irq_pend, m_mstatus[3] && ((m_mip & m_mie) != 0));
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op = CSR_NONE; addr = 12'h0; we = 1'b0; wdata = 0;
    pc = 0; cause = 0; tval = 0; trap = 1'b0; mret = 1'b0; instret = 1'b0;
  endtask

  task automatic csr_set(input zicsr_csr_op_t o, input logic [11:0] a,
                         input logic [31:0] d, input logic w);
    op = o; addr = a; wdata = d; we = w;
  endtask

  logic [11:0] addr_tab [16] = '{12'h300, 12'h301, 12'h304, 12'h305,
                                 12'h340, 12'h341, 12'h342, 12'h343,
                                 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                 12'hB82, 12'hF14, 12'h7C0, 12'hC00};

  initial begin
    idle();
    irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_mtvec", mtvec_o, 32'h0);
    check("rst_mepc", mepc_o, 32'h0);
    check("rst_trap_pc", trap_pc, 32'h0);
    check("rst_irq", irq_pend, 1'b0);
    tick(); tick(); tick();
    csr_set(CSR_RS, 12'hB00, 0, 1'b0); #1 check("mcycle_3", rdata, 32'd3); tick();

    csr_set(CSR_RW, 12'h340, 32'hDEADBEEF, 1'b1); tick();
    csr_set(CSR_RS, 12'h340, 0, 1'b0); #1 check("mscratch", rdata, 32'hDEADBEEF); tick();

    csr_set(CSR_RS, 12'h304, 32'h888, 1'b1); tick();
    csr_set(CSR_RS, 12'h300, 32'h8, 1'b1); tick();
    idle(); irq_timer = 1'b1; tick(); tick();
    #1 check("irq_two_cycles", irq_pend, 1'b1);
    trap = 1'b1; cause = 32'h8000_0007; pc = 32'h104; tick();
    idle(); csr_set(CSR_RS, 12'h300, 0, 1'b0);
    #1 check("mstatus_trap", rdata, 32'h1880);
    check("irq_after_trap", irq_pend, 1'b0);
    tick();
    idle(); mret = 1'b1; tick();
    idle(); csr_set(CSR_RS, 12'h300, 0, 1'b0); #1 check("mstatus_mret", rdata, 32'h1888); tick();

    idle(); csr_set(CSR_RW, 12'h305, 32'h1001, 1'b1); tick();
    idle(); cause = 32'h8000_0007; #1 check("tpc_vectored", trap_pc, 32'h101C);
    cause = 32'h2; #1 check("tpc_direct", trap_pc, 32'h1000);
    csr_set(CSR_RW, 12'h305, 32'h1003, 1'b1); tick();
    idle(); csr_set(CSR_RS, 12'h305, 0, 1'b0); #1 check("mtvec_warl", rdata, 32'h1001); tick();

    csr_set(CSR_RW, 12'hF14, 32'h55, 1'b1);
    #1 check("hartid_wr_ill", illegal, 1'b1); check("hartid_wr_rd", rdata, 32'h0); tick();
    csr_set(CSR_RS, 12'hF14, 0, 1'b0);
    #1 check("hartid_rd_ill", illegal, 1'b0); check("hartid_rd", rdata, 32'h0); tick();
    csr_set(CSR_RS, 12'h7C0, 0, 1'b0);
    #1 check("unimpl_ill", illegal, 1'b1); check("unimpl_rd", rdata, 32'h0); tick();

    csr_set(CSR_RW, 12'hB00, 32'hFFFF_FFFF, 1'b1); tick();
    csr_set(CSR_RW, 12'hB80, 32'hFFFF_FFFF, 1'b1); tick();
    idle(); tick();
    csr_set(CSR_RS, 12'hB00, 0, 1'b0); #1 check("mcycle_wrap_lo", rdata, 32'h0); tick();
    csr_set(CSR_RS, 12'hB80, 0, 1'b0); #1 check("mcycle_wrap_hi", rdata, 32'h0); tick();
    csr_set(CSR_RS, 12'hB00, 0, 1'b0); #1 check("mcycle_after_wrap", rdata, 32'h2); tick();

    csr_set(CSR_RW, 12'hB02, 0, 1'b1); tick();
    csr_set(CSR_RW, 12'hB82, 0, 1'b1); tick();
    idle(); instret = 1'b1;
    repeat (5) tick();
    idle(); csr_set(CSR_RS, 12'hB02, 0, 1'b0); #1 check("minstret_5", rdata, 32'd5); tick();

    idle(); csr_set(CSR_RW, 12'h341, 32'h40, 1'b1);
    trap = 1'b1; pc = 32'h200; cause = 32'h2; tick();
    idle(); csr_set(CSR_RS, 12'h341, 0, 1'b0); #1 check("mepc_trap_wins", rdata, 32'h200); tick();
    csr_set(CSR_RW, 12'h341, 32'h123, 1'b1); tick();
    csr_set(CSR_RS, 12'h341, 0, 1'b0); #1 check("mepc_align", rdata, 32'h120); tick();

    repeat (400) begin
      op    = zicsr_csr_op_t'($urandom_range(0, 3));
      addr  = addr_tab[$urandom_range(0, 15)];
      we    = (op == CSR_RW) ? 1'b1 : 1'($urandom_range(0, 1));
      wdata = $urandom();
      if ($urandom_range(0, 3) == 0) wdata = wdata & 32'h0000_0FFF;
      pc    = $urandom();
      tval  = $urandom();
      cause = {1'($urandom_range(0, 1)), 26'h0, 5'($urandom_range(0, 31))};
      trap  = ($urandom_range(0, 9) == 0);
      mret  = ($urandom_range(0, 7) == 0);
      instret = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) irq_sw    = ~irq_sw;
      if ($urandom_range(0, 3) == 0) irq_timer = ~irq_timer;
      if ($urandom_range(0, 3) == 0) irq_ext   = ~irq_ext;
      rst   = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
